// File: rtl/pixel_stream_tx_pkg.sv
// Shared definitions for the pixel stream transmitter (package pixel_pkg).
// Contents:
//   PIXEL_W   - bits per pixel / stream byte
//   state_t   - transmitter FSM states (CHK is only reachable when the
//               PIXEL_STREAM_TX_CHECKSUM_EN build option is defined)
//   min1_clog2 - ceil(log2(v)) clamped to at least one bit, for counter widths
package pixel_pkg;

  localparam int PIXEL_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CHK  = 2'd2
  } state_t;

  function automatic int min1_clog2(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/pixel_stream_tx_if.sv
// Frame-in / byte-stream-out bus of the pixel stream transmitter.
// Signals:
//   frameIn/frameValid/frameReady  - parallel frame offer (N pixels, row-major)
//   txData/txValid/txReady         - byte stream handshake
//   txSof/txEol/txEof              - start-of-frame, end-of-line, end-of-frame
//   busy                           - transmitter holds a frame
// Modports:
//   master - the transmitter itself
//   slave  - the environment (frame source and byte sink)
interface pixel_stream_tx_if #(
  parameter int N = 16
);
  import pixel_pkg::*;

  logic [N*PIXEL_W-1:0] frameIn;
  logic                 frameValid;
  logic                 frameReady;
  logic [PIXEL_W-1:0]   txData;
  logic                 txValid;
  logic                 txReady;
  logic                 txSof;
  logic                 txEol;
  logic                 txEof;
  logic                 busy;

  modport master (
    input  frameIn, frameValid, txReady,
    output frameReady, txData, txValid, txSof, txEol, txEof, busy
  );

  modport slave (
    output frameIn, frameValid, txReady,
    input  frameReady, txData, txValid, txSof, txEol, txEof, busy
  );

endinterface

// File: rtl/pixel_stream_tx_checksum.sv
// pixel_checksum: running mod-256 sum of the pixels of one frame.
// Only compiled when PIXEL_STREAM_TX_CHECKSUM_EN is defined.
// Ports:
//   clk, reset - clock, asynchronous active-low reset
//   en         - a pixel byte is being handed over this cycle
//   first      - the byte on data is pixel 0 (restarts the sum)
//   data       - byte currently on the stream
//   sum        - sum of all pixels up to and including data (combinational)
`ifdef PIXEL_STREAM_TX_CHECKSUM_EN
module pixel_checksum
  import pixel_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               first,
  input  logic [PIXEL_W-1:0] data,
  output logic [PIXEL_W-1:0] sum
);

  logic [PIXEL_W-1:0] acc_r;

  // Pixel 0 discards whatever the previous frame left in the accumulator.
  assign sum = (first ? 8'd0 : acc_r) + data;

  // Accumulator register, updated on every pixel handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r <= 8'd0;
    end else if (en) begin
      acc_r <= sum;
    end else begin
      acc_r <= acc_r;
    end
  end

endmodule
`endif

// File: rtl/pixel_stream_tx.sv
// pixel_stream_tx: double-buffered frame-to-byte-stream transmitter.
// A parallel frame is captured into a shadow buffer, moved to the active
// buffer and streamed one pixel per handshake, row-major, with SOF/EOL/EOF
// markers. A frame waiting in shadow is streamed straight after the last byte
// of the current one without a gap.
// Build option: PIXEL_STREAM_TX_CHECKSUM_EN appends one mod-256 checksum byte
// per frame (carrying txEof) after pixel N-1.
// Parameters: H rows, W columns, N = H*W pixels.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - pixel_stream_tx_if.master (frame input, byte stream, busy)
module pixel_stream_tx
  import pixel_pkg::*;
#(
  parameter int H = 4,
  parameter int W = 4,
  parameter int N = 16
) (
  input logic                clk,
  input logic                reset,
  pixel_stream_tx_if.master  bus
);

  localparam int IDX_W = min1_clog2(N);
  localparam int COL_W = min1_clog2(W);
  localparam int ROW_W = min1_clog2(H);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(W - 1);

  state_t               state_r;
  logic [N*PIXEL_W-1:0] shadow_r;
  logic [N*PIXEL_W-1:0] active_r;
  logic                 shadow_full_r;
  logic                 active_full_r;
  logic [IDX_W-1:0]     idx_r;
  logic [COL_W-1:0]     col_r;
  logic [ROW_W-1:0]     row_r;
  logic [PIXEL_W-1:0]   tx_data_r;
  logic                 tx_valid_r;
  logic                 tx_sof_r;
  logic                 tx_eol_r;
  logic                 tx_eof_r;

  logic                 handshake_s;
  logic                 accept_s;
  logic                 last_pix_s;
  logic                 end_hs_s;
  logic                 refill_s;
  logic [IDX_W-1:0]     idx_inc_s;
  logic [COL_W-1:0]     col_next_s;
  logic [ROW_W-1:0]     row_next_s;

  function automatic logic [PIXEL_W-1:0] pixel_at(
    input logic [N*PIXEL_W-1:0] frame_v,
    input logic [IDX_W-1:0]     i
  );
    return frame_v[i*PIXEL_W +: PIXEL_W];
  endfunction

  assign handshake_s = tx_valid_r & bus.txReady;
  // Shadow full blocks acceptance, so a load and a refill never collide.
  assign accept_s    = bus.frameValid & ~shadow_full_r;
  assign last_pix_s  = (idx_r == LAST_IDX);
  assign idx_inc_s   = idx_r + IDX_W'(1);

  // Column wraps at W-1 and carries into the row counter.
  always_comb begin
    col_next_s = col_r;
    row_next_s = row_r;
    if (col_r == LAST_COL) begin
      col_next_s = COL_W'(0);
      row_next_s = row_r + ROW_W'(1);
    end else begin
      col_next_s = col_r + COL_W'(1);
    end
  end

`ifdef PIXEL_STREAM_TX_CHECKSUM_EN
  logic [PIXEL_W-1:0] csum_s;

  pixel_checksum u_checksum (
    .clk   (clk),
    .reset (reset),
    .en    (handshake_s & (state_r == SEND)),
    .first (tx_sof_r),
    .data  (tx_data_r),
    .sum   (csum_s)
  );

  // The frame ends on the handshake of the checksum byte.
  assign end_hs_s = handshake_s & (state_r == CHK);
`else
  assign end_hs_s = handshake_s & (state_r == SEND) & last_pix_s;
`endif

  // Shadow moves to active when idle, or on the closing handshake of a frame.
  assign refill_s = shadow_full_r & ((state_r == IDLE) | end_hs_s);

  // Buffers, FSM, counters and registered stream outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      shadow_r      <= '0;
      active_r      <= '0;
      shadow_full_r <= 1'b0;
      active_full_r <= 1'b0;
      idx_r         <= '0;
      col_r         <= '0;
      row_r         <= '0;
      tx_data_r     <= 8'd0;
      tx_valid_r    <= 1'b0;
      tx_sof_r      <= 1'b0;
      tx_eol_r      <= 1'b0;
      tx_eof_r      <= 1'b0;
    end else begin
      if (accept_s) begin
        shadow_r <= bus.frameIn;
      end else begin
        shadow_r <= shadow_r;
      end
      shadow_full_r <= accept_s | (shadow_full_r & ~refill_s);

      if (refill_s) begin
        state_r       <= SEND;
        active_r      <= shadow_r;
        active_full_r <= 1'b1;
        idx_r         <= '0;
        col_r         <= '0;
        row_r         <= '0;
        tx_valid_r    <= 1'b1;
        tx_data_r     <= pixel_at(shadow_r, IDX_W'(0));
        tx_sof_r      <= 1'b1;
        tx_eol_r      <= (LAST_COL == COL_W'(0));
`ifdef PIXEL_STREAM_TX_CHECKSUM_EN
        tx_eof_r      <= 1'b0;
`else
        tx_eof_r      <= (LAST_IDX == IDX_W'(0));
`endif
      end else if (end_hs_s) begin
        state_r       <= IDLE;
        active_full_r <= 1'b0;
        idx_r         <= '0;
        col_r         <= '0;
        row_r         <= '0;
        tx_valid_r    <= 1'b0;
        tx_data_r     <= 8'd0;
        tx_sof_r      <= 1'b0;
        tx_eol_r      <= 1'b0;
        tx_eof_r      <= 1'b0;
`ifdef PIXEL_STREAM_TX_CHECKSUM_EN
      end else if (handshake_s && (state_r == SEND) && last_pix_s) begin
        state_r   <= CHK;
        tx_data_r <= csum_s;
        tx_sof_r  <= 1'b0;
        tx_eol_r  <= 1'b0;
        tx_eof_r  <= 1'b1;
`endif
      end else if (handshake_s && (state_r == SEND)) begin
        idx_r     <= idx_inc_s;
        col_r     <= col_next_s;
        row_r     <= row_next_s;
        tx_data_r <= pixel_at(active_r, idx_inc_s);
        tx_sof_r  <= 1'b0;
        tx_eol_r  <= (col_next_s == LAST_COL);
`ifdef PIXEL_STREAM_TX_CHECKSUM_EN
        tx_eof_r  <= 1'b0;
`else
        tx_eof_r  <= (idx_inc_s == LAST_IDX);
`endif
      end else begin
        // No handshake: everything on the stream holds.
        state_r <= state_r;
      end
    end
  end

  assign bus.frameReady = ~shadow_full_r;
  assign bus.busy       = shadow_full_r | active_full_r;
  assign bus.txData     = tx_data_r;
  assign bus.txValid    = tx_valid_r;
  assign bus.txSof      = tx_sof_r;
  assign bus.txEol      = tx_eol_r;
  assign bus.txEof      = tx_eof_r;

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Self-checking bench for pixel_stream_tx (H=W=4, N=16).
// Expected bytes are queued when a frame is accepted and compared as the
// stream hands them over; stalls are checked for output stability.
module tb_pixel_stream_tx;

  localparam int H = 4;
  localparam int W = 4;
  localparam int N = 16;
`ifdef PIXEL_STREAM_TX_CHECKSUM_EN
  localparam int BPF = N + 1;
`else
  localparam int BPF = N;
`endif

  logic clk;
  logic reset;

  pixel_stream_tx_if #(.N(N)) bus ();

  pixel_stream_tx #(.H(H), .W(W), .N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int hs_count = 0;
  int hs_first = 0;
  int hs_last  = 0;
  int acc_count = 0;

  logic [10:0] exp_q[$];
  logic [10:0] cur_rec;
  logic [10:0] prev_rec;
  logic [10:0] exp_rec;
  logic        prev_stall = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Record layout: {sof, eol, eof, data}
  task automatic push_frame(input logic [N*8-1:0] f);
    logic [7:0] d;
    logic [7:0] sum;
    logic       eof;
    sum = 8'd0;
    for (int i = 0; i < N; i++) begin
      d   = f[i*8 +: 8];
      sum = sum + d;
`ifdef PIXEL_STREAM_TX_CHECKSUM_EN
      eof = 1'b0;
`else
      eof = (i == N - 1);
`endif
      exp_q.push_back({(i == 0), ((i % W) == W - 1), eof, d});
    end
`ifdef PIXEL_STREAM_TX_CHECKSUM_EN
    exp_q.push_back({1'b0, 1'b0, 1'b1, sum});
`endif
  endtask

  function automatic logic [N*8-1:0] ramp_frame();
    logic [N*8-1:0] f;
    for (int i = 0; i < N; i++) f[i*8 +: 8] = 8'(i + 1);
    return f;
  endfunction

  function automatic logic [N*8-1:0] fill_frame(input logic [7:0] v);
    logic [N*8-1:0] f;
    for (int i = 0; i < N; i++) f[i*8 +: 8] = v;
    return f;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: sampled on the falling edge, mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.txValid) begin
        cur_rec = {bus.txSof, bus.txEol, bus.txEof, bus.txData};
        if (prev_stall) check_val("hold", cur_rec, prev_rec);
        if (bus.txReady) begin
          if (exp_q.size() == 0) begin
            check_val("sb_nonempty", exp_q.size(), 1);
          end else begin
            exp_rec = exp_q.pop_front();
            check_val("byte", cur_rec, exp_rec);
          end
          if (hs_count == 0) hs_first = cyc;
          hs_last = cyc;
          hs_count++;
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
        end
        prev_rec = cur_rec;
      end else begin
        prev_stall = 1'b0;
      end
      if (bus.frameValid && bus.frameReady) begin
        push_frame(bus.frameIn);
        acc_count++;
      end
    end
  end

  task automatic clear_stats();
    hs_count  = 0;
    acc_count = 0;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_frame(input logic [N*8-1:0] f);
    int i;
    bus.frameIn    = f;
    bus.frameValid = 1'b1;
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.frameReady) break;
    end
    check_val("accept_wait", (i < 50), 1);
    @(posedge clk); #1;
    bus.frameValid = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.busy) break;
    end
    check_val("drain", exp_q.size(), 0);
    check_val("idle_busy", bus.busy, 0);
  endtask

  initial begin
    int i;
    reset          = 1'b0;
    bus.frameIn    = '0;
    bus.frameValid = 1'b0;
    bus.txReady    = 1'b1;

    // Reset values
    @(negedge clk);
    check_val("rst_valid", bus.txValid, 0);
    check_val("rst_flags", {bus.txSof, bus.txEol, bus.txEof, bus.txData}, 0);
    check_val("rst_ready", bus.frameReady, 1);
    check_val("rst_busy", bus.busy, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // Single frame, sink always ready, latency and no gaps
    clear_stats();
    send_frame(ramp_frame());
    @(negedge clk);
    check_val("lat_k1_valid", bus.txValid, 0);
    check_val("lat_k1_ready", bus.frameReady, 0);
    @(negedge clk);
    check_val("lat_k2_valid", bus.txValid, 1);
    check_val("lat_k2_data", bus.txData, 8'h01);
    drain(60);
    check_val("t1_count", hs_count, BPF);
    check_val("t1_no_bubble", hs_last - hs_first, hs_count - 1);

    // Stall of three cycles on pixel 5 (byte 0x06)
    @(posedge clk); #1;
    clear_stats();
    send_frame(ramp_frame());
    for (i = 0; i < 40; i++) begin
      if (bus.txValid && bus.txData == 8'h06) break;
      @(posedge clk); #1;
    end
    check_val("stall_found", (i < 40), 1);
    bus.txReady = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("stall_data", bus.txData, 8'h06);
    check_val("stall_valid", bus.txValid, 1);
    @(posedge clk); #1;
    bus.txReady = 1'b1;
    drain(60);
    check_val("t2_count", hs_count, BPF);

    // Back-to-back frames 0xAA then 0x55
    @(posedge clk); #1;
    clear_stats();
    send_frame(fill_frame(8'hAA));
    send_frame(fill_frame(8'h55));
    @(negedge clk);
    check_val("b2b_ready", bus.frameReady, 0);
    drain(100);
    check_val("b2b_count", hs_count, 2 * BPF);
    check_val("b2b_no_bubble", hs_last - hs_first, hs_count - 1);

    // frameValid held high while streaming: one extra frame only
    @(posedge clk); #1;
    clear_stats();
    bus.frameIn    = ramp_frame();
    bus.frameValid = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check_val("hold_accepts", acc_count, 2);
    check_val("hold_ready", bus.frameReady, 0);
    @(posedge clk); #1;
    bus.frameValid = 1'b0;
    drain(100);
    check_val("hold_count", hs_count, 2 * BPF);
    check_val("hold_ready_end", bus.frameReady, 1);

    // Asynchronous reset mid-frame at pixel 7 (byte 0x08)
    @(posedge clk); #1;
    clear_stats();
    send_frame(ramp_frame());
    for (i = 0; i < 40; i++) begin
      if (bus.txValid && bus.txData == 8'h08) break;
      @(posedge clk); #1;
    end
    check_val("rst7_found", (i < 40), 1);
    #2 reset = 1'b0;
    #1;
    check_val("arst_valid", bus.txValid, 0);
    check_val("arst_flags", {bus.txSof, bus.txEol, bus.txEof, bus.txData}, 0);
    check_val("arst_ready", bus.frameReady, 1);
    check_val("arst_busy", bus.busy, 0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    for (i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("post_rst_valid", bus.txValid, 0);
    end
    check_val("post_rst_busy", bus.busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pixel_stream_tx.md
PIXEL_STREAM_TX -- requirements
Module: pixel_stream_tx

Interface
- REQ-001: Parameter H, default 4: pixel rows per frame.
- REQ-002: Parameter W, default 4: pixel columns per frame.
- REQ-003: Parameter N, default 16: pixels per frame; SHALL equal H*W.
- REQ-004: clk  input  1  single clock; all state updates on its rising edge.
- REQ-005: reset  input  1  asynchronous, active-low reset.
- REQ-006: frameIn  input  N*8  parallel frame snapshot; pixel i at bits [8i+7:8i], row-major (row = i/W, col = i%W).
- REQ-007: frameValid  input  1  frameIn is valid.
- REQ-008: frameReady  output  1  the shadow buffer can accept a frame.
- REQ-009: txData  output  8  current stream byte.
- REQ-010: txValid  output  1  txData is valid.
- REQ-011: txReady  input  1  sink accepts the byte.
- REQ-012: txSof  output  1  current byte is pixel 0.
- REQ-013: txEol  output  1  current byte is the last pixel of a row (col = W-1).
- REQ-014: txEof  output  1  current byte is the last byte of the frame.
- REQ-015: busy  output  1  active buffer or shadow buffer holds data.

Function
- REQ-016: The block SHALL hold two N*8 buffers: shadow and active, each with a full flag.
- REQ-017: frameReady SHALL equal NOT shadowFull; the frame is accepted on a rising edge where frameValid and frameReady are both high.
- REQ-018: A frame accepted in cycle k SHALL be in shadow at k+1; if the FSM is in IDLE it SHALL move to active at k+1, with txValid high and pixel 0 on txData from cycle k+2.
- REQ-019: FSM states: IDLE (no active data), SEND (streaming active), optionally CHK (see REQ-031).
- REQ-020: Transitions: IDLE->SEND when shadowFull; SEND->IDLE on the last-byte handshake with shadow empty.
- REQ-021: SEND->SEND on the last-byte handshake with shadow full: shadow moves to active and the pixel index resets to 0 with no bubble cycle.
- REQ-022: A handshake SHALL be txValid and txReady high on the same rising edge; the pixel index SHALL increment only on a handshake.
- REQ-023: While txValid=1 and txReady=0, txData, txSof, txEol and txEof SHALL remain stable.
- REQ-024: The pixel index SHALL be log2(N) bits wide, rounded up; the column counter wraps W-1->0 and the row counter increments on that wrap.
- REQ-025: A frame accepted while the shadow is full is impossible because frameReady=0; frameValid is ignored in that case.
- REQ-026: If a shadow load and an active refill from shadow occur on the same edge, the shadow SHALL take the new frame and remain full.
- REQ-027: busy SHALL equal shadowFull OR activeFull.

Reset
- REQ-028: When reset is low, the block SHALL immediately force the FSM to IDLE and clear both full flags, the index and the counters.
- REQ-029: During reset: txValid=0, txData=0, txSof=txEol=txEof=0, frameReady=1, busy=0; a frame in progress SHALL be discarded.

Configuration
- REQ-030: The macro PIXEL_STREAM_TX_CHECKSUM_EN SHALL select the checksum option.
- REQ-031: With the macro defined, after pixel N-1 the FSM SHALL enter CHK and send one byte equal to the sum of all N pixels mod 256; txEof SHALL mark the checksum byte, not pixel N-1.
- REQ-032: Without the macro, there SHALL be no CHK state and no checksum logic, and txEof SHALL mark pixel N-1.

Structure
- REQ-033: Shared package pixel_pkg SHALL hold PIXEL_W=8 and the FSM state enum (IDLE, SEND, CHK).
- REQ-034: One sub-module, pixel_checksum (an accumulator that clears on the first byte), SHALL be instantiated only under PIXEL_STREAM_TX_CHECKSUM_EN.

Verification
- REQ-035: H=W=4, frameIn pixel i = i+1, txReady=1 -> 16 bytes 0x01..0x10 on consecutive cycles starting 2 cycles after accept; txSof on 0x01; txEol on 0x04/0x08/0x0C/0x10; txEof on 0x10.
- REQ-036: Same frame, txReady low for 3 cycles at pixel 5 -> txData held at 0x06 with flags stable; the stream then resumes with no lost or duplicated bytes.
- REQ-037: Two frames (all 0xAA, then all 0x55) offered back-to-back -> frameReady drops after the second accept; 32 bytes stream with no bubble between 0xAA and 0x55.
- REQ-038: reset driven low mid-frame at pixel 7 -> outputs take reset values asynchronously; after release with no new frame, txValid stays 0.
- REQ-039: With CHECKSUM_EN, pixel i = i+1 -> 17th byte 0x88 (136) with txEof, and no txEof on 0x10.
- REQ-040: frameValid held high while streaming -> exactly one extra frame latched; frameReady=0 until that frame moves from shadow to active.
